// File: rtl/multicore_pkg.sv
// Shared types and helpers for the multicore scheduler front-end.
// Holds the sequencer state encoding, arbitration mode codes and a popcount.
package multicore_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } fsm_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Popcount operates on a fixed-width vector; callers zero-extend their request mask.
    localparam int MAX_CORES = 256;
    localparam int PC_W      = 9;

    function automatic logic [PC_W-1:0] popcount(input logic [MAX_CORES-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAX_CORES; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/mc_rr_arbiter.sv
// N-way arbiter with one-hot grant: fixed priority (lowest index) or round-robin.
// The round-robin pointer lives here and moves past the winner on every grant.
module mc_rr_arbiter
    import multicore_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rr_mode,
    input  logic            take,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            grant_vld
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] start;
    logic [2*N-1:0]  rot;
    logic [ID_W-1:0] off;
    logic            found;
    logic [ID_W:0]   sum;

    // Rotate the requests so the search always begins at bit 0, then map back.
    always_comb begin
        start = rr_mode ? ptr : '0;
        rot   = {req, req} >> start;
        found = 1'b0;
        off   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = ID_W'(i);
            end
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= (ID_W+1)'(N)) begin
            sum = sum - (ID_W+1)'(N);
        end
        grant_id  = sum[ID_W-1:0];
        grant_vld = found && take;
        grant     = grant_vld ? (N'(1) << grant_id) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (grant_vld) begin
            ptr <= (grant_id == ID_W'(N-1)) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/multicore_sched.sv
// Multicore front-end: staggered core reset release, result arbitration into a
// registered valid/ready output stage, and a saturating count of lost results.
module multicore_sched
    import multicore_pkg::*;
#(
    parameter int N_CORES  = 29,
    parameter int OUT_W    = 28,
    parameter int EN_W     = 4,
    parameter int STAGGER  = 13,
    parameter int ARB_MODE = 0,
    parameter int CNT_W    = 16,
    parameter int ID_W     = $clog2(N_CORES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     restart,
    input  logic [N_CORES-1:0]       core_mask,
    output logic [N_CORES-1:0]       core_rst,
    input  logic [N_CORES*OUT_W-1:0] core_out,
    input  logic [N_CORES*EN_W-1:0]  core_en,
    output logic                     seq_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic [EN_W-1:0]          out_en,
    output logic [ID_W-1:0]          out_id,
    output logic [CNT_W-1:0]         drop_cnt,
    output fsm_state_t               state_dbg
);

    localparam int SLOT_W = $clog2(N_CORES + 1);
    localparam int CW     = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int SUM_W  = CNT_W + PC_W;

    fsm_state_t          state;
    logic [N_CORES-1:0]  mask_q;
    logic [SLOT_W-1:0]   slot;
    logic [CW-1:0]       cnt;
    logic [N_CORES-1:0]  slot_hot;

    logic [N_CORES-1:0]   req;
    logic [MAX_CORES-1:0] req_ext;
    logic [N_CORES-1:0]   grant;
    logic [ID_W-1:0]      grant_id;
    logic                 grant_vld;
    logic                 take;
    logic [OUT_W-1:0]     sel_data;
    logic [EN_W-1:0]      sel_en;
    logic [PC_W-1:0]      lost;
    logic [SUM_W-1:0]     drop_sum;

    assign state_dbg = state;
    assign slot_hot  = N_CORES'(1) << slot;
    assign take      = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            mask_q   <= '0;
            slot     <= '0;
            cnt      <= '0;
            core_rst <= '1;
            seq_done <= 1'b0;
        end else if (restart) begin
            state    <= IDLE;
            core_rst <= '1;
            seq_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mask_q <= core_mask;
                    slot   <= '0;
                    cnt    <= '0;
                    state  <= RELEASE;
                end
                RELEASE: begin
                    // slot == N_CORES marks the cycle after the last slot has run out.
                    if (slot == SLOT_W'(N_CORES)) begin
                        state    <= RUN;
                        seq_done <= 1'b1;
                    end else begin
                        if (cnt == '0) begin
                            core_rst <= core_rst & ~(mask_q & slot_hot);
                        end
                        if (cnt == CW'(STAGGER - 1)) begin
                            cnt  <= '0;
                            slot <= slot + 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req     = '0;
        req_ext = '0;
        for (int k = 0; k < N_CORES; k++) begin
            req[k] = (core_en[k*EN_W +: EN_W] != '0) && !core_rst[k];
        end
        req_ext[N_CORES-1:0] = req;
    end

    mc_rr_arbiter #(
        .N    (N_CORES),
        .ID_W (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .rr_mode   (ARB_MODE == ARB_RR),
        .take      (take),
        .req       (req),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_vld (grant_vld)
    );

    always_comb begin
        sel_data = '0;
        sel_en   = '0;
        for (int k = 0; k < N_CORES; k++) begin
            if (grant[k]) begin
                sel_data = core_out[k*OUT_W +: OUT_W];
                sel_en   = core_en[k*EN_W +: EN_W];
            end
        end
    end

    // Output stage: valid/ready; a beat transfers when out_valid && out_ready,
    // and a new result may load whenever the register is empty or being drained.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_en    <= '0;
            out_id    <= '0;
        end else if (grant_vld) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_en    <= sel_en;
            out_id    <= grant_id;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Cores pulse their enables, so anything not granted this cycle is gone.
    assign lost     = popcount(req_ext) - PC_W'(grant_vld);
    assign drop_sum = SUM_W'(drop_cnt) + SUM_W'(lost);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (drop_sum[SUM_W-1:CNT_W] != '0) begin
            drop_cnt <= '1;
        end else begin
            drop_cnt <= drop_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_multicore_sched.sv
// Directed bench for multicore_sched: three instances (fixed priority, round-robin,
// 3-bit drop counter) share one stimulus stream and are checked against hand values.
module tb_multicore_sched;
    import multicore_pkg::*;

    localparam int N   = 4;
    localparam int OW  = 28;
    localparam int EW  = 4;
    localparam int IW  = 2;

    logic            clk;
    logic            rst;
    logic            restart;
    logic [N-1:0]    core_mask;
    logic [N*OW-1:0] core_out;
    logic [N*EW-1:0] core_en;
    logic            out_ready;

    logic [N-1:0]  core_rst_a, core_rst_b, core_rst_c;
    logic          seq_done_a, seq_done_b, seq_done_c;
    logic          out_valid_a, out_valid_b, out_valid_c;
    logic [OW-1:0] out_data_a, out_data_b, out_data_c;
    logic [EW-1:0] out_en_a, out_en_b, out_en_c;
    logic [IW-1:0] out_id_a, out_id_b, out_id_c;
    logic [15:0]   drop_cnt_a, drop_cnt_b;
    logic [2:0]    drop_cnt_c;
    fsm_state_t    state_a, state_b, state_c;

    int total = 0;
    int bad   = 0;

    multicore_sched #(.N_CORES(N), .OUT_W(OW), .EN_W(EW), .STAGGER(3), .ARB_MODE(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .restart(restart), .core_mask(core_mask), .core_rst(core_rst_a),
        .core_out(core_out), .core_en(core_en), .seq_done(seq_done_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .out_en(out_en_a), .out_id(out_id_a),
        .drop_cnt(drop_cnt_a), .state_dbg(state_a));

    multicore_sched #(.N_CORES(N), .OUT_W(OW), .EN_W(EW), .STAGGER(3), .ARB_MODE(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .restart(restart), .core_mask(core_mask), .core_rst(core_rst_b),
        .core_out(core_out), .core_en(core_en), .seq_done(seq_done_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .out_en(out_en_b), .out_id(out_id_b),
        .drop_cnt(drop_cnt_b), .state_dbg(state_b));

    multicore_sched #(.N_CORES(N), .OUT_W(OW), .EN_W(EW), .STAGGER(3), .ARB_MODE(0), .CNT_W(3)) dut_c (
        .clk(clk), .rst(rst), .restart(restart), .core_mask(core_mask), .core_rst(core_rst_c),
        .core_out(core_out), .core_en(core_en), .seq_done(seq_done_c), .out_valid(out_valid_c),
        .out_ready(out_ready), .out_data(out_data_c), .out_en(out_en_c), .out_id(out_id_c),
        .drop_cnt(drop_cnt_c), .state_dbg(state_c));

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Driver tasks
    task automatic set_core(input int k, input logic [OW-1:0] d, input logic [EW-1:0] e);
        core_out[k*OW +: OW] = d;
        core_en[k*EW +: EW]  = e;
    endtask

    task automatic apply_reset(input logic [N-1:0] m);
        @(negedge clk);
        rst       = 1'b0;
        restart   = 1'b0;
        core_en   = '0;
        out_ready = 1'b1;
        core_mask = m;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // After this returns, edge E1+13 has passed and the sequencer is in RUN.
    task automatic run_release();
        repeat (14) @(negedge clk);
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        restart   = 1'b0;
        core_mask = '1;
        core_out  = '0;
        core_en   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (core_rst_a !== 4'hF) begin bad++; $display("FAIL reset_core_rst got=%0h exp=f", core_rst_a); end
        total++; if (seq_done_a !== 1'b0) begin bad++; $display("FAIL reset_seq_done got=%0b exp=0", seq_done_a); end
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid_a); end
        total++; if (out_data_a !== '0) begin bad++; $display("FAIL reset_out_data got=%0h exp=0", out_data_a); end
        total++; if (out_en_a !== '0 || out_id_a !== '0) begin bad++; $display("FAIL reset_out_en_id got=%0h/%0h exp=0/0", out_en_a, out_id_a); end
        total++; if (drop_cnt_a !== '0) begin bad++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt_a); end
        total++; if (state_a !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state_a, IDLE); end
    endtask

    // Edge n=1 is E1; core k (enabled) falls at edge 2+3k, seq_done at edge 14.
    task automatic test_release_timing(input logic [N-1:0] m);
        logic [N-1:0] exp_rst;
        logic         exp_done;
        apply_reset(m);
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                exp_rst[k] = !(m[k] && (n >= 2 + 3 * k));
            end
            exp_done = (n >= 14);
            total++; if (core_rst_a !== exp_rst) begin bad++; $display("FAIL release_core_rst mask=%b edge=%0d got=%b exp=%b", m, n, core_rst_a, exp_rst); end
            total++; if (seq_done_a !== exp_done) begin bad++; $display("FAIL release_seq_done mask=%b edge=%0d got=%0b exp=%0b", m, n, seq_done_a, exp_done); end
        end
    endtask

    task automatic test_fixed_priority();
        logic [OW-1:0] neg5;
        neg5 = -28'sd5;
        apply_reset(4'hF);
        run_release();
        set_core(1, 28'd100, 4'd1);
        set_core(3, neg5, 4'd1);
        out_ready = 1'b1;
        @(negedge clk);
        core_en = '0;
        total++; if (out_valid_a !== 1'b1) begin bad++; $display("FAIL fixed_valid got=%0b exp=1", out_valid_a); end
        total++; if (out_data_a !== 28'd100) begin bad++; $display("FAIL fixed_data got=%0d exp=100", out_data_a); end
        total++; if (out_id_a !== 2'd1) begin bad++; $display("FAIL fixed_id got=%0d exp=1", out_id_a); end
        total++; if (out_en_a !== 4'd1) begin bad++; $display("FAIL fixed_en got=%0d exp=1", out_en_a); end
        total++; if (drop_cnt_a !== 16'd1) begin bad++; $display("FAIL fixed_drop got=%0d exp=1", drop_cnt_a); end
        @(negedge clk);
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL fixed_drain got=%0b exp=0", out_valid_a); end
        total++; if (drop_cnt_a !== 16'd1) begin bad++; $display("FAIL fixed_drop_hold got=%0d exp=1", drop_cnt_a); end
    endtask

    // All four cores request for four cycles: RR walks 0..3, fixed stays on 0,
    // and the 3-bit counter saturates at 7 once 9 requests have been lost.
    task automatic test_round_robin();
        logic [OW-1:0] rr_data [N];
        int            exp_c;
        rr_data[0] = 28'd10;
        rr_data[1] = 28'd20;
        rr_data[2] = 28'd30;
        rr_data[3] = -28'sd5;
        apply_reset(4'hF);
        run_release();
        for (int k = 0; k < N; k++) set_core(k, rr_data[k], EW'(k + 1));
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            exp_c = (3 * (i + 1) > 7) ? 7 : 3 * (i + 1);
            total++; if (out_id_b !== IW'(i)) begin bad++; $display("FAIL rr_id cycle=%0d got=%0d exp=%0d", i, out_id_b, i); end
            total++; if (out_data_b !== rr_data[i]) begin bad++; $display("FAIL rr_data cycle=%0d got=%0h exp=%0h", i, out_data_b, rr_data[i]); end
            total++; if (out_en_b !== EW'(i + 1)) begin bad++; $display("FAIL rr_en cycle=%0d got=%0d exp=%0d", i, out_en_b, i + 1); end
            total++; if (drop_cnt_b !== 16'(3 * (i + 1))) begin bad++; $display("FAIL rr_drop cycle=%0d got=%0d exp=%0d", i, drop_cnt_b, 3 * (i + 1)); end
            total++; if (out_id_a !== 2'd0) begin bad++; $display("FAIL fixed_b2b_id cycle=%0d got=%0d exp=0", i, out_id_a); end
            total++; if (drop_cnt_c !== 3'(exp_c)) begin bad++; $display("FAIL sat_drop cycle=%0d got=%0d exp=%0d", i, drop_cnt_c, exp_c); end
        end
        core_en = '0;
    endtask

    task automatic test_backpressure_restart();
        apply_reset(4'hF);
        run_release();
        set_core(0, 28'd55, 4'd2);
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid_a !== 1'b1 || out_data_a !== 28'd55) begin bad++; $display("FAIL bp_load got=%0b/%0d exp=1/55", out_valid_a, out_data_a); end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_core(0, 28'(200 + i), 4'd1);
            @(negedge clk);
            total++; if (out_valid_a !== 1'b1 || out_data_a !== 28'd55 || out_en_a !== 4'd2) begin
                bad++; $display("FAIL bp_hold cycle=%0d got=%0b/%0d/%0d exp=1/55/2", i, out_valid_a, out_data_a, out_en_a);
            end
        end
        core_en = '0;
        total++; if (drop_cnt_a !== 16'd5) begin bad++; $display("FAIL bp_drop got=%0d exp=5", drop_cnt_a); end
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        total++; if (core_rst_a !== 4'hF || seq_done_a !== 1'b0) begin bad++; $display("FAIL restart_rst got=%h/%0b exp=f/0", core_rst_a, seq_done_a); end
        total++; if (out_valid_a !== 1'b1 || out_data_a !== 28'd55) begin bad++; $display("FAIL restart_out_kept got=%0b/%0d exp=1/55", out_valid_a, out_data_a); end
        total++; if (drop_cnt_a !== 16'd5) begin bad++; $display("FAIL restart_drop_kept got=%0d exp=5", drop_cnt_a); end
        total++; if (state_a !== IDLE) begin bad++; $display("FAIL restart_state got=%0d exp=%0d", state_a, IDLE); end
        @(negedge clk);
        total++; if (core_rst_a !== 4'hF) begin bad++; $display("FAIL restart_idle_rst got=%h exp=f", core_rst_a); end
        @(negedge clk);
        total++; if (core_rst_a !== 4'hE) begin bad++; $display("FAIL restart_rerelease got=%h exp=e", core_rst_a); end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL restart_accept got=%0b exp=0", out_valid_a); end
    endtask

    task automatic test_async_reset();
        apply_reset(4'hF);
        repeat (6) @(negedge clk);
        total++; if (core_rst_a !== 4'b1100) begin bad++; $display("FAIL mid_release_rst got=%b exp=1100", core_rst_a); end
        set_core(0, 28'd77, 4'd1);
        set_core(1, 28'd88, 4'd1);
        @(negedge clk);
        core_en = '0;
        total++; if (out_valid_a !== 1'b1 || out_data_a !== 28'd77 || drop_cnt_a !== 16'd1) begin
            bad++; $display("FAIL mid_release_grant got=%0b/%0d/%0d exp=1/77/1", out_valid_a, out_data_a, drop_cnt_a);
        end
        total++; if (state_a !== RELEASE) begin bad++; $display("FAIL mid_release_state got=%0d exp=%0d", state_a, RELEASE); end
        #2 rst = 1'b0;
        #1;
        total++; if (core_rst_a !== 4'hF || seq_done_a !== 1'b0) begin bad++; $display("FAIL async_rst_core got=%h/%0b exp=f/0", core_rst_a, seq_done_a); end
        total++; if (out_valid_a !== 1'b0 || out_data_a !== '0 || out_id_a !== '0) begin
            bad++; $display("FAIL async_rst_out got=%0b/%0d/%0d exp=0/0/0", out_valid_a, out_data_a, out_id_a);
        end
        total++; if (drop_cnt_a !== '0 || state_a !== IDLE) begin bad++; $display("FAIL async_rst_cnt got=%0d/%0d exp=0/%0d", drop_cnt_a, state_a, IDLE); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_release_timing(4'b1111);
        test_release_timing(4'b1011);
        test_fixed_priority();
        test_round_robin();
        test_backpressure_restart();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicore_sched.md
# multicore_sched

Parametrised multicore front-end for the rede_float network. It releases the core resets one at a time on a fixed stagger, keeps masked cores in reset, and selects one core result per cycle by fixed-priority or round-robin arbitration. The selected result goes into a registered valid/ready output stage, and results that cannot be taken are counted. It sits between the shared input bus and N rede_float instances and replaces the hard-wired 29-core wrapper.

## Interface
- N_CORES, 29: number of rede_float cores.
- OUT_W, 28: signed result width per core.
- EN_W, 4: per-core out_en field width.
- STAGGER, 13: cycles between consecutive core reset releases (≥1).
- ARB_MODE, 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
- CNT_W, 16: drop-counter width.
- ID_W, $clog2(N_CORES): core-id width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- restart  in  1  sync pulse; re-runs the release sequence.
- core_mask  in  N_CORES  1 = core enabled; sampled at reset exit and on restart.
- core_rst  out  N_CORES  per-core active-high reset to rede_float.
- core_out  in  N_CORES*OUT_W  packed core results; core k is at [k*OUT_W +: OUT_W].
- core_en  in  N_CORES*EN_W  packed core out_en fields.
- seq_done  out  1  all enabled cores released.
- out_valid  out  1  result register holds data.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  selected result.
- out_en  out  EN_W  selected out_en field.
- out_id  out  ID_W  index of the selected core.
- drop_cnt  out  CNT_W  saturating count of lost results.

## Operation
- **Reset (rst low).** core_rst all 1, seq_done 0, out_valid 0, out_data/out_en/out_id 0, drop_cnt 0, state IDLE, rr pointer 0.
- **FSM states: IDLE → RELEASE → RUN.**
  - IDLE lasts exactly one cycle after rst rises. In it, the block latches core_mask into mask_q, sets slot=0 and cnt=0.
  - RELEASE: in slot k, core_rst[k] is cleared on the first cycle of the slot if mask_q[k]=1. A masked core stays in reset permanently.
  - Each slot lasts STAGGER cycles, counted by cnt from 0 to STAGGER-1. Masked slots still take STAGGER cycles, so the timing stays deterministic.
  - After slot N_CORES-1 completes, the FSM enters RUN and seq_done=1.
- **Restart.** restart=1 in any state: core_rst goes all 1, seq_done=0, FSM returns to IDLE, the output register and drop_cnt are untouched. restart has priority over a slot advance in the same cycle.
- **Request.** Core k requests when its core_en field is nonzero and core_rst[k]=0.
- **Grant and load.** A grant happens when (!out_valid || out_ready) and at least one request exists.
  - The granted core's core_out, core_en and index are loaded into the output register, and out_valid is set.
  - out_valid is cleared when it is accepted (out_valid && out_ready) in a cycle with no grant.
- **Arbitration.**
  - Fixed priority: the lowest requesting index wins.
  - Round-robin: the search starts at the rr pointer; after a grant to core g, the pointer becomes (g+1) mod N_CORES. The pointer is unchanged when there is no grant.
- **Drops.** Cores pulse core_en and do not hold it.
  - Every request not granted in its cycle is lost: requests−1 if a grant occurred, otherwise all requests.
  - drop_cnt adds the number lost that cycle (popcount) and saturates at 2^CNT_W−1.
- **Width.** out_data is passed through unchanged (signed OUT_W). No arithmetic is applied to results.

## Timing
- Edge E1 is the first rising edge with rst high; it is the IDLE cycle.
- core_rst[k] falls at edge E1 + 1 + k*STAGGER (enabled k).
- seq_done rises at edge E1 + 1 + N_CORES*STAGGER.
- Request-to-output latency is 1 cycle: a request sampled at edge t appears on out_* after edge t.
- Back-to-back grants sustain 1 result/cycle while out_ready=1.
- While out_valid && !out_ready, the output is stable and every request in that cycle is dropped.
- rst assertion mid-operation clears everything asynchronously. Deassertion restarts from IDLE.

## Structure
- Shared package multicore_pkg holds:
  - the FSM state enum (IDLE, RELEASE, RUN);
  - the ARB_MODE encodings (ARB_FIXED=0, ARB_RR=1);
  - a popcount function.
- One sub-module, mc_rr_arbiter (N-way, one-hot grant, mode input, pointer register inside).
- The sequencer, output register and drop counter live in the top level.

## Test plan
- **Release timing.** N=4, STAGGER=3, mask=4'b1111, release rst → core_rst falls at E1+1, +4, +7, +10; seq_done at E1+13.
- **Masked core.** mask=4'b1011 → core_rst[2] stays 1 throughout; seq_done still at E1+13.
- **Fixed priority.** Cores 1 and 3 pulse core_en=1 with data 100 and −5 in the same cycle, out_ready=1 → out_data=100, out_id=1 next cycle; drop_cnt=1.
- **Round-robin.** ARB_MODE=1; all 4 cores request for 4 consecutive cycles → out_id sequence 0,1,2,3; drop_cnt increases by 3 per cycle (12 total).
- **Backpressure and restart.**
  - Hold out_ready=0 with out_valid=1 while core 0 pulses 5 times → out_data held stable, drop_cnt=5.
  - Assert restart in RUN → core_rst all 1, out_valid and drop_cnt kept.
- **Saturation and reset.**
  - CNT_W=3: 9 dropped requests → drop_cnt=7.
  - Pulse rst low mid-RELEASE → all outputs return to reset values immediately.
